// File: rtl/cpu_bus_pkg.sv
// Shared bus definitions for the 19-bit CPU datapath: source count, select type
// and the source indices allocated by the datapath.
package cpu_bus_pkg;

  localparam int NUM_BUS_SRC = 16;
  localparam int BUS_SEL_W   = 4;

  typedef logic [BUS_SEL_W-1:0] bus_sel_t;

  localparam bus_sel_t SRC_PC  = 4'd0;
  localparam bus_sel_t SRC_ACC = 4'd1;
  localparam bus_sel_t SRC_IR  = 4'd2;
  localparam bus_sel_t SRC_MAR = 4'd3;
  localparam bus_sel_t SRC_MDR = 4'd4;
  localparam bus_sel_t SRC_SP  = 4'd5;
  localparam bus_sel_t SRC_ALU = 4'd6;
  localparam bus_sel_t SRC_IO  = 4'd7;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority pick: first set request after 'last',
// wrapping, ending at 'last' itself. last = N-1 gives plain lowest-index priority.
module rr_pick #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] winner,
  output logic         found
);

  logic [2*N-1:0] dbl;
  int             idx;

  // Doubling the vector turns the wrap-around into a linear window
  // (last, last+N]; the lowest set bit inside that window wins.
  always_comb begin
    dbl   = {req, req};
    found = 1'b0;
    idx   = 0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i] && (i > int'(last)) && (i <= int'(last) + N)) begin
        found = 1'b1;
        idx   = i;
      end
    end
    winner = (idx >= N) ? W'(idx - N) : W'(idx);
  end

endmodule

// File: rtl/bus_source_arbiter.sv
// Registered shared-bus source arbiter: fixed or round-robin priority, grant
// locking for multi-cycle transfers, per-cycle and sticky conflict flags.
module bus_source_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int NUM_SRC     = NUM_BUS_SRC,
  parameter int SEL_W       = $clog2(NUM_SRC),
  parameter int DEFAULT_SEL = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               rr_mode,
  input  logic               lock,
  input  logic               err_clr,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic [NUM_SRC-1:0] grant,
  output logic               conflict,
  output logic               conflict_sticky
);

  logic [SEL_W-1:0]   last, last_n, sel_n, rr_last, winner;
  logic [NUM_SRC-1:0] grant_n;
  logic               valid_n, found, hold, conflict_n, sticky_n;

  assign rr_last = rr_mode ? last : SEL_W'(NUM_SRC - 1);

  rr_pick #(
    .N (NUM_SRC),
    .W (SEL_W)
  ) u_pick (
    .req    (req),
    .last   (rr_last),
    .winner (winner),
    .found  (found)
  );

  always_comb begin
    sel_n      = sel;
    valid_n    = sel_valid;
    grant_n    = grant;
    last_n     = last;
    // grant is one-hot at sel whenever valid, so this is req[sel] && sel_valid
    hold       = lock && (|(req & grant));
    conflict_n = |(req & (req - NUM_SRC'(1)));
    sticky_n   = conflict_n | (conflict_sticky & ~err_clr);
    if (hold) begin
      sel_n   = sel;
      valid_n = 1'b1;
      grant_n = grant;
    end else if (!found) begin
      sel_n   = SEL_W'(DEFAULT_SEL);
      valid_n = 1'b0;
      grant_n = '0;
    end else begin
      sel_n   = winner;
      valid_n = 1'b1;
      grant_n = NUM_SRC'(1) << winner;
      last_n  = winner;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel             <= SEL_W'(DEFAULT_SEL);
      sel_valid       <= 1'b0;
      grant           <= '0;
      conflict        <= 1'b0;
      conflict_sticky <= 1'b0;
      last            <= SEL_W'(NUM_SRC - 1);
    end else begin
      sel             <= sel_n;
      sel_valid       <= valid_n;
      grant           <= grant_n;
      conflict        <= conflict_n;
      conflict_sticky <= sticky_n;
      last            <= last_n;
    end
  end

endmodule

// File: doc/bus_source_arbiter.md
Name: bus_source_arbiter

Overview:
Parametrised successor to the combinational bus-control encoder of the 19-bit CPU. It takes NUM_SRC bus-drive request lines and produces a registered source select for the shared-bus mux, together with a one-hot grant. It adds:
- fixed-priority and round-robin arbitration modes;
- grant locking for multi-cycle transfers;
- conflict detection, both per-cycle and sticky.

With exactly one request active it reproduces the legacy encoding, index i gives select i, one cycle later.

Parameters:
NUM_SRC, 16, number of bus sources; legal range 2..64.
SEL_W, $clog2(NUM_SRC), select width; must be at least $clog2(NUM_SRC).
DEFAULT_SEL, 0, select value driven when no request is granted.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  synchronous reset, active-low.
req  input  NUM_SRC  request vector; bit i = source i (legacy x0 is bit 0).
rr_mode  input  1  0 = fixed priority (lowest index wins); 1 = round-robin.
lock  input  1  hold the current grant while its requester stays asserted.
err_clr  input  1  clears conflict_sticky.
sel  output  SEL_W  registered bus-mux select.
sel_valid  output  1  registered; 1 when sel reflects a real grant.
grant  output  NUM_SRC  registered one-hot grant (all zeros when sel_valid = 0).
conflict  output  1  registered; 1 when more than one req bit was set in the previous cycle.
conflict_sticky  output  1  set by any conflict; held until err_clr.

Behaviour:
- Reset: synchronous, active-low. Sampled at the clk edge while rst_n = 0, it sets:
  - sel = DEFAULT_SEL, sel_valid = 0, grant = 0;
  - conflict = 0, conflict_sticky = 0;
  - internal rr pointer last = NUM_SRC-1, so the first round-robin search starts at 0.
  - Reset overrides every other input, including mid-lock.
- Latency: 1 cycle. req sampled at edge N appears on sel/grant after edge N.
- Winner selection, evaluated each cycle in this order:
  1. Lock: if lock = 1, sel_valid = 1 and req[sel] = 1, hold sel and grant unchanged. The rr pointer does not move. Conflict detection still runs.
  2. req = 0: sel = DEFAULT_SEL, sel_valid = 0, grant = 0. The rr pointer is unchanged.
  3. Fixed mode (rr_mode = 0): winner = lowest set index.
  4. Round-robin (rr_mode = 1): winner = first set index searching last+1, last+2, …, wrapping modulo NUM_SRC. The search ends at last itself, so a sole requester equal to last is re-granted.
  - Outputs for cases 3–4: sel = winner, grant = 1 << winner, sel_valid = 1, last = winner.
- last updates on every new grant in either mode. Switching rr_mode takes effect on the next evaluation, with no flush.
- Lock with a dropped requester (lock = 1 but req[sel] = 0): treated as no lock; normal arbitration runs that cycle.
- Conflict:
  - conflict = (popcount(req) > 1), registered.
  - conflict_sticky next = conflict_condition OR (sticky AND NOT err_clr). A new conflict in the same cycle as err_clr leaves the flag set (set wins).
- Width rule: sel is zero-extended when SEL_W > $clog2(NUM_SRC). Indices of NUM_SRC or more are never produced.
- Invariant: grant is always one-hot or zero, and grant[sel] = sel_valid.

Decomposition:
- Shared package cpu_bus_pkg:
  - NUM_BUS_SRC = 16;
  - BUS_SEL_W = 4;
  - named source index constants (SRC_PC, SRC_ACC, … as allocated by the datapath);
  - typedef bus_sel_t.
- One sub-module: rr_pick. Combinational; given req and last, it returns the winner index and a found flag using a doubled-vector mask-and-priority scheme. Fixed mode reuses it with last = NUM_SRC-1.

Test Plan:
- Legacy equivalence: rr_mode = 0, drive req = 1<<i for i = 0..15 over consecutive cycles → one cycle later sel = i, grant = 1<<i, sel_valid = 1, conflict = 0.
- Fixed priority with conflict: req = 0x0024 (bits 2 and 5) → sel = 2, conflict = 1, conflict_sticky = 1; then req = 0 → sel = 0, sel_valid = 0, conflict = 0, sticky stays 1.
- Round-robin rotation: rr_mode = 1, req = 0x8011 held constant from reset → sel sequence 0, 4, 15, 0, 4.
- Lock: rr_mode = 1, req = 0x0003, lock = 1 after the first grant (sel = 0) → sel stays 0 for 5 cycles. Drop req[0] → next cycle sel = 1.
- Sticky clear priority: err_clr = 1 with req = 0x0001 → sticky clears to 0. err_clr = 1 with req = 0x0003 → sticky remains 1.
- Reset mid-lock: lock = 1, sel = 7, then rst_n = 0 for one edge → sel = 0, sel_valid = 0, grant = 0, sticky = 0. Next RR grant with req = 0x0081 → sel = 0.
